// File: rtl/sip_pkg.sv
// Shared constants and encodings for the six-instruction processor datapath.
package sip_pkg;

  localparam int SIP_DATA_W   = 16;
  localparam int SIP_RF_DEPTH = 16;
  localparam int SIP_IADDR_W  = 16;
  localparam int SIP_DADDR_W  = 8;
  localparam int INSTR_W      = 16;

  typedef enum logic [3:0] {
    OP_MOV_RD = 4'd0,  // MOV Ra,d
    OP_MOV_WR = 4'd1,  // MOV d,Ra
    OP_ADD    = 4'd2,
    OP_MOV_C  = 4'd3,  // MOV Ra,C
    OP_SUB    = 4'd4,
    OP_JMPZ   = 4'd5
  } opcode_e;

  typedef enum logic [1:0] {
    RF_SRC_ALU   = 2'b00,
    RF_SRC_DMEM  = 2'b01,
    RF_SRC_CONST = 2'b10,
    RF_SRC_ILL   = 2'b11
  } rf_src_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_ILL  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/sip_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
module sip_regfile #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] p_addr,
  output logic [W-1:0]  p_data,
  input  logic [AW-1:0] q_addr,
  output logic [W-1:0]  q_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: this storage is reset entry by entry, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign p_data = mem[p_addr];
  assign q_data = mem[q_addr];

endmodule

// File: rtl/sip_datapath.sv
// Datapath and fetch unit: PC, IR, register file, write-source mux, ALU and error flag.
module sip_datapath
  import sip_pkg::*;
#(
  parameter int DATA_W   = SIP_DATA_W,
  parameter int RF_DEPTH = SIP_RF_DEPTH,
  parameter int RF_AW    = $clog2(SIP_RF_DEPTH),
  parameter int IADDR_W  = SIP_IADDR_W,
  parameter int DADDR_W  = SIP_DADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PC_clr,
  input  logic               PC_ld,
  input  logic               PC_inc,
  input  logic               I_rd,
  input  logic               IR_ld,
  input  logic               D_rd,
  input  logic               D_wr,
  input  logic               RF_s1,
  input  logic               RF_s0,
  input  logic               RF_W_wr,
  input  logic               RF_Rp_rd,
  input  logic               RF_Rq_rd,
  input  logic [RF_AW-1:0]   RF_W_addr,
  input  logic [RF_AW-1:0]   RF_Rp_addr,
  input  logic [RF_AW-1:0]   RF_Rq_addr,
  input  logic               alu_s1,
  input  logic               alu_s0,
  output logic [INSTR_W-1:0] instr,
  output logic               RF_Rp_zero,
  output logic [IADDR_W-1:0] imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_rd,
  output logic               dmem_wr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               proto_err
);

  logic [IADDR_W-1:0] pc;
  logic [IADDR_W-1:0] pc_off;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  rp_raw, rq_raw, rp_data, rq_data;
  logic [DATA_W-1:0]  alu_y, wr_data, const_ext;
  logic               perr_set;
  rf_src_e            rf_src;
  alu_op_e            alu_op;

  assign rf_src    = rf_src_e'({RF_s1, RF_s0});
  assign alu_op    = alu_op_e'({alu_s1, alu_s0});
  assign const_ext = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign pc_off    = {{(IADDR_W-8){ir[7]}}, ir[7:0]};

  sip_regfile #(.W(DATA_W), .DEPTH(RF_DEPTH), .AW(RF_AW)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RF_W_wr),
    .waddr  (RF_W_addr),
    .wdata  (wr_data),
    .p_addr (RF_Rp_addr),
    .p_data (rp_raw),
    .q_addr (RF_Rq_addr),
    .q_data (rq_raw)
  );

  assign rp_data    = RF_Rp_rd ? rp_raw : '0;
  assign rq_data    = RF_Rq_rd ? rq_raw : '0;
  assign RF_Rp_zero = RF_Rp_rd && (rp_raw == '0);

  // NOTE: a default is assigned before the case so no path can infer a latch.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_PASS: alu_y = rp_data;
      ALU_ADD:  alu_y = rp_data + rq_data;
      ALU_SUB:  alu_y = rp_data - rq_data;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    wr_data = '0;
    case (rf_src)
      RF_SRC_ALU:   wr_data = alu_y;
      RF_SRC_DMEM:  wr_data = dmem_rdata;
      RF_SRC_CONST: wr_data = const_ext;
      default:      wr_data = '0;
    endcase
  end

  // Illegal ALU code only matters when its result is actually written back.
  assign perr_set = (D_rd && D_wr)
                 || (IR_ld && !I_rd)
                 || (RF_W_wr && rf_src == RF_SRC_ILL)
                 || (RF_W_wr && rf_src == RF_SRC_ALU && alu_op == ALU_ILL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      proto_err <= 1'b0;
    end else begin
      if (PC_clr)      pc <= '0;
      else if (PC_ld)  pc <= pc + pc_off - IADDR_W'(1);  // fetch already advanced PC
      else if (PC_inc) pc <= pc + IADDR_W'(1);
      if (IR_ld && I_rd) ir <= imem_rdata;
      if (perr_set) proto_err <= 1'b1;
    end
  end

  assign instr      = ir;
  assign imem_addr  = pc;
  assign imem_rd    = I_rd;
  assign dmem_addr  = ir[DADDR_W-1:0];
  assign dmem_wdata = rp_data;
  assign dmem_rd    = D_rd;
  assign dmem_wr    = D_wr;

endmodule

// File: tb/tb_sip_datapath.sv
// Self-checking bench for sip_datapath: directed scenarios plus randomized cycles against a behavioural model.
module tb_sip_datapath;

  logic        clk, rst;
  logic        PC_clr, PC_ld, PC_inc, I_rd, IR_ld, D_rd, D_wr;
  logic        RF_s1, RF_s0, RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0;
  logic [3:0]  RF_W_addr, RF_Rp_addr, RF_Rq_addr;
  logic [15:0] instr, imem_addr, imem_rdata, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_addr;
  logic        RF_Rp_zero, imem_rd, dmem_rd, dmem_wr, proto_err;

  sip_datapath dut (
    .clk(clk), .rst(rst),
    .PC_clr(PC_clr), .PC_ld(PC_ld), .PC_inc(PC_inc),
    .I_rd(I_rd), .IR_ld(IR_ld), .D_rd(D_rd), .D_wr(D_wr),
    .RF_s1(RF_s1), .RF_s0(RF_s0),
    .RF_W_wr(RF_W_wr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd),
    .RF_W_addr(RF_W_addr), .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
    .alu_s1(alu_s1), .alu_s0(alu_s0),
    .instr(instr), .RF_Rp_zero(RF_Rp_zero),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_rdata(dmem_rdata),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model of architectural state.
  logic [15:0] m_pc, m_ir;
  logic [15:0] m_rf [16];
  logic        m_perr;

  task automatic idle();
    PC_clr = 0; PC_ld = 0; PC_inc = 0; I_rd = 0; IR_ld = 0; D_rd = 0; D_wr = 0;
    RF_s1 = 0; RF_s0 = 0; RF_W_wr = 0; RF_Rp_rd = 0; RF_Rq_rd = 0;
    RF_W_addr = 0; RF_Rp_addr = 0; RF_Rq_addr = 0; alu_s1 = 0; alu_s0 = 0;
    imem_rdata = 0; dmem_rdata = 0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_perr = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
  endtask

  // One clock: evaluate the instruction-level rules on the current controls, then commit.
  task automatic tick();
    int rp, rq, res, w, sel, aluc, off;
    rp   = RF_Rp_rd ? int'(m_rf[RF_Rp_addr]) : 0;
    rq   = RF_Rq_rd ? int'(m_rf[RF_Rq_addr]) : 0;
    aluc = int'({alu_s1, alu_s0});
    sel  = int'({RF_s1, RF_s0});
    off  = int'($signed(m_ir[7:0]));
    res  = (aluc == 0) ? rp : (aluc == 1) ? rp + rq : (aluc == 2) ? rp - rq : 0;
    w    = (sel == 0) ? res : (sel == 1) ? int'(dmem_rdata) : (sel == 2) ? off : 0;
    @(posedge clk);
    if ((D_rd && D_wr) || (IR_ld && !I_rd) || (RF_W_wr && sel == 3) ||
        (RF_W_wr && sel == 0 && aluc == 3)) m_perr = 1;
    if (RF_W_wr) m_rf[RF_W_addr] = 16'(w);
    if (PC_clr)      m_pc = 0;
    else if (PC_ld)  m_pc = 16'(int'(m_pc) + off - 1);
    else if (PC_inc) m_pc = 16'(int'(m_pc) + 1);
    if (IR_ld && I_rd) m_ir = imem_rdata;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [15:0] word);
    idle(); imem_rdata = word; I_rd = 1; IR_ld = 1; PC_inc = 1; tick(); idle();
  endtask

  task automatic load_const(input logic [3:0] r, input logic [7:0] c);
    fetch({4'h3, r, c});
    RF_s1 = 1; RF_W_wr = 1; RF_W_addr = r; tick(); idle();
  endtask

  task automatic load_dmem(input logic [3:0] r, input logic [15:0] v);
    idle(); dmem_rdata = v; D_rd = 1; RF_s0 = 1; RF_W_wr = 1; RF_W_addr = r; tick(); idle();
  endtask

  task automatic alu_write(input logic [1:0] op, input logic [3:0] p, input logic [3:0] q,
                           input logic [3:0] w);
    idle(); {alu_s1, alu_s0} = op; RF_Rp_rd = 1; RF_Rq_rd = 1;
    RF_Rp_addr = p; RF_Rq_addr = q; RF_W_wr = 1; RF_W_addr = w; tick(); idle();
  endtask

  task automatic apply_reset();
    idle(); #2 rst = 1; model_reset();
    @(posedge clk); @(negedge clk); rst = 0; idle();
  endtask

  task automatic test_reset();
    load_const(4'd5, 8'h44);
    load_dmem(4'd9, 16'h1234);
    D_rd = 1; D_wr = 1; tick(); idle();
    // Mid-instruction: a write, fetch and increment are pending when rst rises.
    RF_s1 = 1; RF_W_wr = 1; RF_W_addr = 4'd5; PC_inc = 1; I_rd = 1; IR_ld = 1; imem_rdata = 16'hFFFF;
    #2 rst = 1; model_reset();
    #1;
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h want 0000", imem_addr); end
    checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_ir: got %h want 0000", instr); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", proto_err); end
    @(posedge clk);
    RF_Rp_rd = 1;
    for (int i = 0; i < 16; i++) begin
      RF_Rp_addr = 4'(i); #1;
      checks++;
      if (dmem_wdata !== 16'h0) begin errors++; $display("FAIL reset_r%0d: got %h want 0000", i, dmem_wdata); end
    end
    RF_Rp_addr = 0; #1;
    checks++; if (RF_Rp_zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", RF_Rp_zero); end
    @(negedge clk); rst = 0; idle(); #1;
    checks++; if ({imem_addr, instr} !== 32'h0) begin errors++; $display("FAIL reset_hold: pc/ir got %h want 0", {imem_addr, instr}); end
  endtask

  task automatic test_fetch_const();
    idle(); imem_rdata = 16'h3105; I_rd = 1; IR_ld = 1; PC_inc = 1; #1;
    checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL imem_rd: got %b want 1", imem_rd); end
    tick(); idle(); #1;
    checks++; if (instr !== 16'h3105) begin errors++; $display("FAIL fetch_ir: got %h want 3105", instr); end
    checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL fetch_pc: got %h want 0001", imem_addr); end
    RF_s1 = 1; RF_W_wr = 1; RF_W_addr = 4'd1; tick(); idle();
    RF_Rp_rd = 1; RF_Rp_addr = 4'd1; #1;
    checks++; if (dmem_wdata !== 16'h0005) begin errors++; $display("FAIL const_pos: got %h want 0005", dmem_wdata); end
    fetch(16'h3180);
    RF_s1 = 1; RF_W_wr = 1; RF_W_addr = 4'd1; tick(); idle();
    RF_Rp_rd = 1; RF_Rp_addr = 4'd1; #1;
    checks++; if (dmem_wdata !== 16'hFF80) begin errors++; $display("FAIL const_neg: got %h want ff80", dmem_wdata); end
    checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL fetch_pc2: got %h want %h", imem_addr, m_pc); end
  endtask

  task automatic test_arith();
    load_const(4'd1, 8'h05);
    load_const(4'd2, 8'hFE);
    alu_write(2'b01, 4'd1, 4'd2, 4'd3);
    RF_Rp_rd = 1; RF_Rp_addr = 4'd3; #1;
    checks++; if (dmem_wdata !== 16'h0003) begin errors++; $display("FAIL add: got %h want 0003", dmem_wdata); end
    alu_write(2'b10, 4'd1, 4'd2, 4'd3);
    RF_Rp_rd = 1; RF_Rp_addr = 4'd3; #1;
    checks++; if (dmem_wdata !== 16'h0007) begin errors++; $display("FAIL sub: got %h want 0007", dmem_wdata); end
    load_dmem(4'd6, 16'h8000);
    load_dmem(4'd7, 16'h8000);
    alu_write(2'b01, 4'd6, 4'd7, 4'd8);
    RF_Rp_rd = 1; RF_Rp_addr = 4'd8; #1;
    checks++; if (dmem_wdata !== 16'h0000) begin errors++; $display("FAIL add_wrap: got %h want 0000", dmem_wdata); end
    alu_write(2'b00, 4'd2, 4'd1, 4'd9);
    RF_Rp_rd = 1; RF_Rp_addr = 4'd9; #1;
    checks++; if (dmem_wdata !== 16'hFFFE) begin errors++; $display("FAIL pass: got %h want fffe", dmem_wdata); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL arith_perr: got %b want 0", proto_err); end
  endtask

  task automatic test_dmem();
    idle(); dmem_rdata = 16'hABCD; D_rd = 1; RF_s0 = 1; RF_W_wr = 1; RF_W_addr = 4'd4; #1;
    checks++; if ({dmem_rd, dmem_wr} !== 2'b10) begin errors++; $display("FAIL dmem_strobe_rd: got %b want 10", {dmem_rd, dmem_wr}); end
    tick(); idle();
    RF_Rp_rd = 1; RF_Rp_addr = 4'd4; #1;
    checks++; if (dmem_wdata !== 16'hABCD) begin errors++; $display("FAIL dmem_load: got %h want abcd", dmem_wdata); end
    fetch(16'h1422);
    D_wr = 1; RF_Rp_rd = 1; RF_Rp_addr = 4'd4; #1;
    checks++; if (dmem_addr !== 8'h22) begin errors++; $display("FAIL dmem_addr: got %h want 22", dmem_addr); end
    checks++; if (dmem_wdata !== 16'hABCD) begin errors++; $display("FAIL dmem_wdata: got %h want abcd", dmem_wdata); end
    checks++; if ({dmem_rd, dmem_wr} !== 2'b01) begin errors++; $display("FAIL dmem_strobe_wr: got %b want 01", {dmem_rd, dmem_wr}); end
    tick(); idle();
  endtask

  task automatic test_jump();
    PC_clr = 1; tick(); idle();
    PC_inc = 1; repeat (4) tick(); idle();
    fetch(16'h50FD); #1;
    checks++; if ({imem_addr, instr} !== {16'h0005, 16'h50FD}) begin errors++; $display("FAIL jmp_setup: got %h want 000550fd", {imem_addr, instr}); end
    load_dmem(4'd0, 16'h0000);
    RF_Rp_rd = 1; RF_Rp_addr = 4'd0; #1;
    checks++; if (RF_Rp_zero !== 1'b1) begin errors++; $display("FAIL jmp_zero: got %b want 1", RF_Rp_zero); end
    PC_ld = 1; tick(); idle(); #1;
    checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL jmp_back: got %h want 0001", imem_addr); end
    load_dmem(4'd0, 16'h0007);
    RF_Rp_rd = 1; RF_Rp_addr = 4'd0; #1;
    checks++; if (RF_Rp_zero !== 1'b0) begin errors++; $display("FAIL jmp_nonzero: got %b want 0", RF_Rp_zero); end
    RF_Rp_rd = 0; RF_Rp_addr = 4'd8; #1;
    checks++; if (RF_Rp_zero !== 1'b0) begin errors++; $display("FAIL zero_gated: got %b want 0", RF_Rp_zero); end
    PC_clr = 1; RF_Rp_rd = 0; tick(); idle();
    fetch(16'h50FF);
    PC_ld = 1; tick(); idle(); #1;
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL jmp_wrap: got %h want ffff", imem_addr); end
    PC_inc = 1; tick(); idle(); #1;
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h want 0000", imem_addr); end
  endtask

  task automatic test_errors();
    PC_inc = 1; tick(); idle();
    PC_clr = 1; PC_ld = 1; PC_inc = 1; tick(); idle(); #1;
    checks++; if ({imem_addr, proto_err} !== 17'h0) begin errors++; $display("FAIL pc_priority: got %h want 0", {imem_addr, proto_err}); end
    D_rd = 1; D_wr = 1; tick(); idle(); #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_dmem: got %b want 1", proto_err); end
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky%0d: got %b want 1", i, proto_err); end
    end
    apply_reset(); #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b want 0", proto_err); end
    load_const(4'd6, 8'h11);
    RF_s1 = 1; RF_s0 = 1; RF_W_wr = 1; RF_W_addr = 4'd6; tick(); idle();
    RF_Rp_rd = 1; RF_Rp_addr = 4'd6; #1;
    checks++; if ({dmem_wdata, proto_err} !== {16'h0, 1'b1}) begin errors++; $display("FAIL rfsel11: got %h want 00001", {dmem_wdata, proto_err}); end
    apply_reset();
    fetch(16'h3107);
    IR_ld = 1; imem_rdata = 16'hBEEF; tick(); idle(); #1;
    checks++; if ({instr, proto_err} !== {16'h3107, 1'b1}) begin errors++; $display("FAIL irld_nord: got %h want 62 0f", {instr, proto_err}); end
    apply_reset();
    load_const(4'd2, 8'h09);
    alu_write(2'b11, 4'd2, 4'd2, 4'd2);
    RF_Rp_rd = 1; RF_Rp_addr = 4'd2; #1;
    checks++; if ({dmem_wdata, proto_err} !== {16'h0, 1'b1}) begin errors++; $display("FAIL alu11_wr: got %h want 00001", {dmem_wdata, proto_err}); end
    apply_reset();
    alu_s1 = 1; alu_s0 = 1; tick(); idle();
    alu_s1 = 1; alu_s0 = 1; dmem_rdata = 16'h5A5A; RF_s0 = 1; RF_W_wr = 1; RF_W_addr = 4'd3; tick(); idle();
    RF_Rp_rd = 1; RF_Rp_addr = 4'd3; #1;
    checks++; if ({dmem_wdata, proto_err} !== {16'h5A5A, 1'b0}) begin errors++; $display("FAIL alu11_unused: got %h want b4b4 0", {dmem_wdata, proto_err}); end
  endtask

  task automatic test_random();
    logic [15:0] exp_rp;
    logic        exp_zero;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      PC_clr = 1'($urandom_range(0, 15) == 0); PC_ld = 1'($urandom_range(0, 7) == 0);
      PC_inc = 1'($urandom_range(0, 1)); I_rd = 1'($urandom_range(0, 1)); IR_ld = 1'($urandom_range(0, 1));
      D_rd = 1'($urandom_range(0, 1)); D_wr = 1'($urandom_range(0, 1));
      RF_s1 = 1'($urandom_range(0, 1)); RF_s0 = 1'($urandom_range(0, 1)); RF_W_wr = 1'($urandom_range(0, 1));
      RF_Rp_rd = 1'($urandom_range(0, 3) != 0); RF_Rq_rd = 1'($urandom_range(0, 3) != 0);
      RF_W_addr = 4'($urandom_range(0, 15)); RF_Rp_addr = 4'($urandom_range(0, 15)); RF_Rq_addr = 4'($urandom_range(0, 15));
      alu_s1 = 1'($urandom_range(0, 1)); alu_s0 = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom); dmem_rdata = 16'($urandom);
      if (n < 300) begin  // legal controls only, so the flag stays observable at the end
        if (D_rd) D_wr = 0;
        if (IR_ld) I_rd = 1;
        if (RF_s1 && RF_s0) RF_s0 = 0;
        if (!RF_s1 && !RF_s0 && alu_s1 && alu_s0) alu_s0 = 0;
      end
      exp_rp   = RF_Rp_rd ? m_rf[RF_Rp_addr] : 16'h0;
      exp_zero = RF_Rp_rd && (m_rf[RF_Rp_addr] == 16'h0);
      #1;
      checks++;
      if ({instr, imem_addr, proto_err} !== {m_ir, m_pc, m_perr}) begin
        errors++; $display("FAIL rand_state[%0d]: ir/pc/perr got %h/%h/%b want %h/%h/%b",
                           n, instr, imem_addr, proto_err, m_ir, m_pc, m_perr);
      end
      checks++;
      if ({dmem_wdata, RF_Rp_zero, dmem_addr} !== {exp_rp, exp_zero, m_ir[7:0]}) begin
        errors++; $display("FAIL rand_read[%0d]: wdata/zero/addr got %h/%b/%h want %h/%b/%h",
                           n, dmem_wdata, RF_Rp_zero, dmem_addr, exp_rp, exp_zero, m_ir[7:0]);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1; model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_fetch_const();
    test_arith();
    test_dmem();
    test_jump();
    test_errors();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
